// File: rtl/box_param_ctrl_if.sv
// Bundle of key inputs, frame sync and published box outputs shared by
// box_param_ctrl and its environment.
interface box_param_ctrl_if;
  logic [4:0] key_in;
  logic       vsync;
  logic [9:0] x;
  logic [9:0] y;
  logic [9:0] w;
  logic [9:0] h;
  logic [1:0] mode;
  logic       box_en;

  modport master (
    output key_in, vsync,
    input  x, y, w, h, mode, box_en
  );

  modport slave (
    input  key_in, vsync,
    output x, y, w, h, mode, box_en
  );
endinterface

// File: rtl/box_param_ctrl.sv
// Key-driven box position/size controller: debounced buttons edit a working
// rectangle that is published to the display stage only on vsync edges.
module box_param_ctrl #(
  parameter int DB_CNT_MAX = 1485000,
  parameter int STEP       = 8,
  parameter int X_LIMIT    = 1023,
  parameter int Y_LIMIT    = 719,
  parameter int W_MIN      = 16,
  parameter int H_MIN      = 16,
  parameter int X0         = 100,
  parameter int Y0         = 100,
  parameter int W0         = 200,
  parameter int H0         = 150
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  box_param_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_MOVE = 2'd1,
    ST_SIZE = 2'd2
  } state_t;

  localparam int          CW        = $clog2(DB_CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT_MAX - 1);
  localparam logic [10:0] ST11      = 11'(STEP);
  localparam logic [9:0]  ST10      = 10'(STEP);
  localparam logic [10:0] XL11      = 11'(X_LIMIT);
  localparam logic [9:0]  XL10      = 10'(X_LIMIT);
  localparam logic [10:0] YL11      = 11'(Y_LIMIT);
  localparam logic [9:0]  YL10      = 10'(Y_LIMIT);
  localparam logic [10:0] WSHR11    = 11'(W_MIN + STEP);
  localparam logic [10:0] HSHR11    = 11'(H_MIN + STEP);
  localparam logic [9:0]  WMIN10    = 10'(W_MIN);
  localparam logic [9:0]  HMIN10    = 10'(H_MIN);

  logic [4:0]    key_meta;
  logic [4:0]    key_sync;
  logic [4:0]    db;
  logic [4:0]    db_d;
  logic [CW-1:0] cnt [5];
  logic [4:0]    press;
  logic          ev_mode, ev_left, ev_right, ev_up, ev_down;

  state_t        state, state_n;
  logic [9:0]    wx, wy, ww, wh;
  logic [9:0]    wx_n, wy_n, ww_n, wh_n;
  logic [10:0]   sum_x, sum_y;

  logic          vs_r, vs_d, vs_rise;
  logic [9:0]    x_q, y_q, w_q, h_q;
  logic          en_q;

  // Two-flop synchronizer for the asynchronous buttons (released = 1).
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta <= 5'h1f;
      key_sync <= 5'h1f;
    end else begin
      key_meta <= bus.key_in;
      key_sync <= key_meta;
    end
  end

  // Per-key debouncer: level flips after DB_CNT_MAX consecutive differing clocks.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      db   <= 5'h1f;
      db_d <= 5'h1f;
      for (int i = 0; i < 5; i++) cnt[i] <= {CW{1'b0}};
    end else begin
      db_d <= db;
      for (int i = 0; i < 5; i++) begin
        if (key_sync[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= key_sync[i];
            cnt[i] <= {CW{1'b0}};
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= {CW{1'b0}};
        end
      end
    end
  end

  assign press    = db_d & ~db;
  assign ev_mode  = press[0];
  assign ev_left  = press[1] & ~press[0];
  assign ev_right = press[2] & ~(|press[1:0]);
  assign ev_up    = press[3] & ~(|press[2:0]);
  assign ev_down  = press[4] & ~(|press[3:0]);

  assign sum_x = {1'b0, wx} + {1'b0, ww} + ST11;
  assign sum_y = {1'b0, wy} + {1'b0, wh} + ST11;

  // Next mode and next working rectangle from the winning press event.
  always_comb begin
    state_n = state;
    wx_n    = wx;
    wy_n    = wy;
    ww_n    = ww;
    wh_n    = wh;
    if (ev_mode) begin
      case (state)
        ST_OFF:  state_n = ST_MOVE;
        ST_MOVE: state_n = ST_SIZE;
        ST_SIZE: state_n = ST_OFF;
        default: state_n = ST_OFF;
      endcase
    end else begin
      case (state)
        ST_MOVE: begin
          if (ev_left) begin
            wx_n = ({1'b0, wx} >= ST11) ? (wx - ST10) : 10'd0;
          end else if (ev_right) begin
            wx_n = (sum_x <= XL11) ? (wx + ST10) : (XL10 - ww);
          end else if (ev_up) begin
            wy_n = ({1'b0, wy} >= ST11) ? (wy - ST10) : 10'd0;
          end else if (ev_down) begin
            wy_n = (sum_y <= YL11) ? (wy + ST10) : (YL10 - wh);
          end else begin
            wx_n = wx;
          end
        end
        ST_SIZE: begin
          if (ev_left) begin
            ww_n = ({1'b0, ww} >= WSHR11) ? (ww - ST10) : WMIN10;
          end else if (ev_right) begin
            ww_n = (sum_x <= XL11) ? (ww + ST10) : (XL10 - wx);
          end else if (ev_up) begin
            wh_n = ({1'b0, wh} >= HSHR11) ? (wh - ST10) : HMIN10;
          end else if (ev_down) begin
            wh_n = (sum_y <= YL11) ? (wh + ST10) : (YL10 - wy);
          end else begin
            ww_n = ww;
          end
        end
        default: wx_n = wx;
      endcase
    end
  end

  // Mode state and working rectangle registers.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_OFF;
      wx    <= 10'(X0);
      wy    <= 10'(Y0);
      ww    <= 10'(W0);
      wh    <= 10'(H0);
    end else begin
      state <= state_n;
      wx    <= wx_n;
      wy    <= wy_n;
      ww    <= ww_n;
      wh    <= wh_n;
    end
  end

  assign vs_rise = vs_r & ~vs_d;

  // Frame-synchronous publish; uses pre-event values when an event coincides.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_r <= 1'b0;
      vs_d <= 1'b0;
      x_q  <= 10'd0;
      y_q  <= 10'd0;
      w_q  <= 10'd0;
      h_q  <= 10'd0;
      en_q <= 1'b0;
    end else begin
      vs_r <= bus.vsync;
      vs_d <= vs_r;
      if (vs_rise) begin
        if (state == ST_OFF) begin
          x_q  <= 10'd0;
          y_q  <= 10'd0;
          w_q  <= 10'd0;
          h_q  <= 10'd0;
          en_q <= 1'b0;
        end else begin
          x_q  <= wx;
          y_q  <= wy;
          w_q  <= ww;
          h_q  <= wh;
          en_q <= 1'b1;
        end
      end
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.w      = w_q;
  assign bus.h      = h_q;
  assign bus.box_en = en_q;
  assign bus.mode   = state;

endmodule

// File: tb/tb_box_param_ctrl.sv
// Self-checking bench for box_param_ctrl with a short debounce time
// (DB_CNT_MAX=4): table of key actions plus hand-built corner sequences.
module tb_box_param_ctrl;

  typedef struct {
    logic [4:0] keys;
    int         reps;
    logic [9:0] ex, ey, ew, eh;
    logic [1:0] em;
    logic       een;
  } vec_t;

  typedef struct {
    logic [9:0] x, y, w, h;
    logic [1:0] m;
    logic       en;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs [18];
  exp_t sb_q [$];

  box_param_ctrl_if bus ();

  box_param_ctrl #(.DB_CNT_MAX(4)) dut (
    .vga_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [4:0] k, input int r,
                         input int x, input int y, input int w, input int h,
                         input int m, input int en);
    vecs[i].keys = k;
    vecs[i].reps = r;
    vecs[i].ex   = 10'(x);
    vecs[i].ey   = 10'(y);
    vecs[i].ew   = 10'(w);
    vecs[i].eh   = 10'(h);
    vecs[i].em   = 2'(m);
    vecs[i].een  = 1'(en);
  endtask

  task automatic press(input logic [4:0] mask);
    @(negedge clk);
    bus.key_in = ~mask;
    repeat (8) @(negedge clk);
    bus.key_in = 5'h1f;
    repeat (8) @(negedge clk);
  endtask

  task automatic push_exp(input int x, input int y, input int w, input int h,
                          input int m, input int en);
    exp_t e;
    e.x = 10'(x); e.y = 10'(y); e.w = 10'(w); e.h = 10'(h);
    e.m = 2'(m);  e.en = 1'(en);
    sb_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got 0 expected 1 entries", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".x"},      32'(bus.x),      32'(e.x));
      chk({tag, ".y"},      32'(bus.y),      32'(e.y));
      chk({tag, ".w"},      32'(bus.w),      32'(e.w));
      chk({tag, ".h"},      32'(bus.h),      32'(e.h));
      chk({tag, ".mode"},   32'(bus.mode),   32'(e.m));
      chk({tag, ".box_en"}, 32'(bus.box_en), 32'(e.en));
    end
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    bus.vsync = 1'b1;
    repeat (3) @(negedge clk);
    bus.vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //           keys    reps  x    y    w    h   m en
    set_vec(0,  5'h01, 1,   100, 100, 200, 150, 1, 1);
    set_vec(1,  5'h02, 12,  4,   100, 200, 150, 1, 1);
    set_vec(2,  5'h02, 1,   0,   100, 200, 150, 1, 1);
    set_vec(3,  5'h04, 102, 816, 100, 200, 150, 1, 1);
    set_vec(4,  5'h04, 1,   823, 100, 200, 150, 1, 1);
    set_vec(5,  5'h02, 2,   807, 100, 200, 150, 1, 1);
    set_vec(6,  5'h01, 1,   807, 100, 200, 150, 2, 1);
    set_vec(7,  5'h04, 2,   807, 100, 216, 150, 2, 1);
    set_vec(8,  5'h04, 1,   807, 100, 216, 150, 2, 1);
    set_vec(9,  5'h08, 30,  807, 100, 216, 16,  2, 1);
    set_vec(10, 5'h08, 1,   807, 100, 216, 16,  2, 1);
    set_vec(11, 5'h06, 1,   807, 100, 208, 16,  2, 1);
    set_vec(12, 5'h10, 1,   807, 100, 208, 24,  2, 1);
    set_vec(13, 5'h01, 1,   0,   0,   0,   0,   0, 0);
    set_vec(14, 5'h02, 3,   0,   0,   0,   0,   0, 0);
    set_vec(15, 5'h01, 1,   807, 100, 208, 24,  1, 1);
    set_vec(16, 5'h10, 1,   807, 108, 208, 24,  1, 1);
    set_vec(17, 5'h08, 2,   807, 92,  208, 24,  1, 1);

    bus.key_in = 5'h1f;
    bus.vsync  = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    push_exp(0, 0, 0, 0, 0, 0);
    check_out("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) press(vecs[i].keys);
      chk($sformatf("v%0d.mode_live", i), 32'(bus.mode), 32'(vecs[i].em));
      push_exp(vecs[i].ex, vecs[i].ey, vecs[i].ew, vecs[i].eh, vecs[i].em, vecs[i].een);
      vs_pulse();
      check_out($sformatf("v%0d", i));
    end

    // Bouncing left key never settles long enough to register.
    for (int t = 0; t < 10; t++) begin
      @(negedge clk); bus.key_in = 5'h1d;
      @(negedge clk);
      @(negedge clk); bus.key_in = 5'h1f;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    push_exp(807, 92, 208, 24, 1, 1);
    vs_pulse();
    check_out("bounce");

    // Press without vsync holds outputs; next vsync publishes.
    press(5'h04);
    repeat (1000) @(negedge clk);
    push_exp(807, 92, 208, 24, 1, 1);
    check_out("no_vsync_hold");
    push_exp(815, 92, 208, 24, 1, 1);
    vs_pulse();
    check_out("vsync_publish");

    // Press event and vsync rise land in the same cycle: publish pre-event value.
    @(negedge clk);
    bus.key_in = 5'h1d;
    repeat (5) @(negedge clk);
    bus.vsync = 1'b1;
    @(negedge clk);
    bus.vsync = 1'b0;
    repeat (3) @(negedge clk);
    push_exp(815, 92, 208, 24, 1, 1);
    check_out("coincident_pre");
    bus.key_in = 5'h1f;
    repeat (10) @(negedge clk);
    push_exp(807, 92, 208, 24, 1, 1);
    vs_pulse();
    check_out("coincident_post");

    // vsync held high: edits accumulate but outputs stay frozen.
    @(negedge clk);
    bus.vsync = 1'b1;
    repeat (4) @(negedge clk);
    press(5'h02);
    repeat (200) @(negedge clk);
    push_exp(807, 92, 208, 24, 1, 1);
    check_out("vsync_high_hold");
    bus.vsync = 1'b0;
    repeat (50) @(negedge clk);
    push_exp(807, 92, 208, 24, 1, 1);
    check_out("vsync_low_hold");
    push_exp(799, 92, 208, 24, 1, 1);
    vs_pulse();
    check_out("vsync_after_hold");

    // Reset mid-debounce discards the pending press and restores the reset box.
    @(negedge clk);
    bus.key_in = 5'h1b;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    push_exp(0, 0, 0, 0, 0, 0);
    check_out("reset_async");
    bus.key_in = 5'h1f;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    push_exp(0, 0, 0, 0, 0, 0);
    vs_pulse();
    check_out("post_reset_off");
    press(5'h01);
    push_exp(100, 100, 200, 150, 1, 1);
    vs_pulse();
    check_out("post_reset_box");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
